mem_port: RTL

- Memory access sequencer between the CPU register buses and external 16-bit memory.
- Captures an address (from a register's A bus) and write data (from the B bus).
- Runs a handshaked read or write cycle with wait states and timeout.
- On completion, drives the register-side strobes: LDN to load read data, and IDN/INC_DECN for post-access ±2 of the address register (PC/SP style).

---
 rtl/mem_port_if.sv | 39 +++
 rtl/mem_port.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_if.sv
// Bundle of the register-side and memory-side signals of mem_port.
// The slave modport is the sequencer. The master modport is whatever surrounds it: the CPU
// register buses together with the external memory.
interface mem_port_if;
  // Register / CPU side
  logic        REQ;
  logic        WR;
  logic        POST_ID;
  logic        POST_INC;
  logic [15:0] ADDR;
  logic [15:0] WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [1:0]  ERR_CODE;
  logic [15:0] RDATA;
  logic        LDN;
  logic        IDN;
  logic        INC_DECN;
  // Memory side
  logic [14:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic        MEM_CSN;
  logic        MEM_WEN;
  logic [15:0] MEM_RDATA;
  logic        MEM_RDY;

  modport slave (
    input  REQ, WR, POST_ID, POST_INC, ADDR, WDATA, MEM_RDATA, MEM_RDY,
    output BUSY, DONE, ERR, ERR_CODE, RDATA, LDN, IDN, INC_DECN,
    output MEM_ADDR, MEM_WDATA, MEM_CSN, MEM_WEN
  );

  modport master (
    output REQ, WR, POST_ID, POST_INC, ADDR, WDATA, MEM_RDATA, MEM_RDY,
    input  BUSY, DONE, ERR, ERR_CODE, RDATA, LDN, IDN, INC_DECN,
    input  MEM_ADDR, MEM_WDATA, MEM_CSN, MEM_WEN
  );
endinterface

// File: rtl/mem_port.sv
// Memory access sequencer between the CPU register buses and a 16-bit external memory.
// It captures an access, runs a handshaked read or write with a wait-state timeout, and then
// issues the register-side load and inc/dec strobes. Every output is a register. Each output
// register is loaded from the next-state value, so an output changes on the same edge that
// the state does.
module mem_port #(
  // Maximum WAIT cycles before abort, 2..255
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic     CLK,
  input  logic     RESET,
  mem_port_if.slave bus
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StSetup    = 3'd1;
  localparam logic [2:0] StWait     = 3'd2;
  localparam logic [2:0] StComplete = 3'd3;
  localparam logic [2:0] StFault    = 3'd4;

  localparam logic [1:0] CodeNone       = 2'b00;
  localparam logic [1:0] CodeMisaligned = 2'b01;
  localparam logic [1:0] CodeTimeout    = 2'b10;

  // The counter value seen during the last permitted WAIT cycle
  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        accept;
  logic        wr_q, wr_d;
  logic        post_id_q, post_id_d;
  logic        post_inc_q, post_inc_d;
  logic        mem_active_d;

  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic [15:0] rdata_q;
  logic        ldn_q;
  logic        idn_q;
  logic [14:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        mem_csn_q;
  logic        mem_wen_q;

  // Sequencer next state and wait-state counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.REQ) begin
          accept  = 1'b1;
          state_d = bus.ADDR[0] ? StFault : StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A ready in the final permitted cycle still completes the access
        if (bus.MEM_RDY) begin
          state_d = StComplete;
        end else if (cnt_q == WaitLast) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StComplete: state_d = StIdle;
      StFault:    state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // The request attributes are captured on the edge that accepts the request
  always_comb begin
    wr_d         = accept ? bus.WR       : wr_q;
    post_id_d    = accept ? bus.POST_ID  : post_id_q;
    post_inc_d   = accept ? bus.POST_INC : post_inc_q;
    mem_active_d = (state_d == StSetup) || (state_d == StWait);
  end

  // Sequencer state and captured request attributes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      post_id_q  <= 1'b0;
      post_inc_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      post_id_q  <= post_id_d;
      post_inc_q <= post_inc_d;
    end
  end

  // Registered strobes, memory controls and status, derived from the next state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ldn_q       <= 1'b1;
      idn_q       <= 1'b1;
      mem_csn_q   <= 1'b1;
      mem_wen_q   <= 1'b1;
    end else begin
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StComplete);
      err_q     <= (state_d == StFault);
      ldn_q     <= !((state_d == StComplete) && !wr_d);
      idn_q     <= !((state_d == StComplete) && post_id_d);
      mem_csn_q <= !mem_active_d;
      mem_wen_q <= !(mem_active_d && wr_d);
    end
  end

  // Error code: cleared by an accepted request and set when an access aborts
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_code_q <= CodeNone;
    end else if (accept) begin
      err_code_q <= bus.ADDR[0] ? CodeMisaligned : CodeNone;
    end else if ((state_q == StWait) && (state_d == StFault)) begin
      err_code_q <= CodeTimeout;
    end
  end

  // Memory address and write data are loaded only for aligned accesses and then held
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (accept && !bus.ADDR[0]) begin
      mem_addr_q  <= bus.ADDR[15:1];
      mem_wdata_q <= bus.WDATA;
    end
  end

  // Read data register: loaded from memory on the ready edge of a read, otherwise held
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rdata_q <= '0;
    end else if ((state_q == StWait) && bus.MEM_RDY && !wr_q) begin
      rdata_q <= bus.MEM_RDATA;
    end
  end

  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  assign bus.ERR_CODE  = err_code_q;
  assign bus.RDATA     = rdata_q;
  assign bus.LDN       = ldn_q;
  assign bus.IDN       = idn_q;
  assign bus.INC_DECN  = post_inc_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_WDATA = mem_wdata_q;
  assign bus.MEM_CSN   = mem_csn_q;
  assign bus.MEM_WEN   = mem_wen_q;

endmodule
